// File: rtl/life_scan_loader.sv
// Scan-port driver for the 4x4 life array: loads a preset pattern or
// rotates the chain for read-back, capturing the bits that leave it.
module life_scan_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 scan_read_val,
    output logic                 scan,
    output logic                 scan_write_enb,
    output logic                 scan_write_val,
    output logic                 hold_run,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] readback
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SHIFT  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] pat_sr;
    logic                 mode_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pat_sr   <= '0;
            mode_q   <= 1'b0;
            readback <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_sr <= pattern;
                        mode_q <= mode;
                        cnt    <= '0;
                        state  <= SETTLE;
                    end
                end
                SETTLE: state <= SHIFT;
                SHIFT: begin
                    pat_sr   <= {1'b0, pat_sr[CHAIN_LEN-1:1]};
                    readback <= {scan_read_val, readback[CHAIN_LEN-1:1]};
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset drops them without a clock.
    assign scan           = (state == SHIFT);
    assign scan_write_enb = scan;
    assign scan_write_val = scan & (mode_q ? scan_read_val : pat_sr[0]);
    assign busy           = (state != IDLE);
    assign hold_run       = busy;
    assign done           = (state == DONE);

endmodule

// File: tb/tb_life_scan_loader.sv
// Self-checking bench for life_scan_loader against a behavioural chain
// and an operation-level reference model of the array contents.
module tb_life_scan_loader;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         mode;
    logic [N-1:0] pattern;
    logic         scan_read_val;
    logic         scan;
    logic         scan_write_enb;
    logic         scan_write_val;
    logic         hold_run;
    logic         busy;
    logic         done;
    logic [N-1:0] readback;

    int vectors     = 0;
    int miscompares = 0;

    // Stand-in for the array's scan chain: head at MSB, tail at bit 0.
    logic [N-1:0] chain = '0;
    logic [N-1:0] ref_arr = '0;

    life_scan_loader #(.CHAIN_LEN(N), .CNT_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .pattern        (pattern),
        .scan_read_val  (scan_read_val),
        .scan           (scan),
        .scan_write_enb (scan_write_enb),
        .scan_write_val (scan_write_val),
        .hold_run       (hold_run),
        .busy           (busy),
        .done           (done),
        .readback       (readback)
    );

    always #5 clk = ~clk;

    assign scan_read_val = chain[0];

    always @(posedge clk)
        if (scan_write_enb)
            chain <= {scan_write_val, chain[N-1:1]};

    typedef struct {
        logic         m;
        logic [N-1:0] p;
        logic [N-1:0] exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One operation: start at negedge before E0, observe 24 cycles.
    task automatic run_op(input logic m, input logic [N-1:0] p,
                          input int hold_cyc, input logic [N-1:0] late_p,
                          output logic [N-1:0] rb);
        logic [24:0] scan_map, hold_map, busy_map, done_map;
        logic        bad;
        logic [24:0] exp_scan, exp_hold, exp_done;
        scan_map = '0; hold_map = '0; busy_map = '0; done_map = '0;
        bad = 1'b0;
        rb = 'x;
        @(negedge clk);
        start = 1'b1; mode = m; pattern = p;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            scan_map[c] = scan;
            hold_map[c] = hold_run;
            busy_map[c] = busy;
            done_map[c] = done;
            if (scan_write_enb !== scan) bad = 1'b1;
            if (!scan && scan_write_val !== 1'b0) bad = 1'b1;
            if (done) rb = readback;
            if (c >= hold_cyc) start = 1'b0;
            if (c == 2) pattern = late_p;
        end
        exp_scan = ((25'd1 << N) - 25'd1) << 2;
        exp_hold = ((25'd1 << (N + 2)) - 25'd1) << 1;
        exp_done = 25'd1 << (N + 2);
        chk("done_timing", 32'(done_map), 32'(exp_done));
        chk("scan_window", 32'(scan_map), 32'(exp_scan));
        chk("hold_window", 32'(hold_map), 32'(exp_hold));
        chk("busy_window", 32'(busy_map), 32'(exp_hold));
        chk("write_enb_val", 32'(bad), 32'd0);
    endtask

    task automatic model_op(input logic m, input logic [N-1:0] p,
                            output logic [N-1:0] exp);
        exp = ref_arr;
        if (!m) ref_arr = p;
    endtask

    initial begin
        logic [N-1:0] rb, exp;
        logic         m;
        logic [N-1:0] p;

        reset = 1'b1; start = 1'b0; mode = 1'b0; pattern = '0;
        repeat (2) @(negedge clk);
        chk("rst_scan", 32'(scan), 32'd0);
        chk("rst_swe", 32'(scan_write_enb), 32'd0);
        chk("rst_hold", 32'(hold_run), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_readback", 32'(readback), 32'd0);
        reset = 1'b0;

        tbl[0] = '{1'b1, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 16'hA5C3, 16'h0000};
        tbl[2] = '{1'b1, 16'h0000, 16'hA5C3};
        tbl[3] = '{1'b1, 16'h0000, 16'hA5C3};
        tbl[4] = '{1'b0, 16'h0F0F, 16'hA5C3};
        tbl[5] = '{1'b1, 16'h0000, 16'h0F0F};

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].m, tbl[i].p, 1, tbl[i].p, rb);
            model_op(tbl[i].m, tbl[i].p, exp);
            chk($sformatf("tbl%0d_readback", i), 32'(rb), 32'(tbl[i].exp));
        end

        // Start held 3 cycles, pattern swapped mid-operation: one op only.
        run_op(1'b0, 16'h3C5A, 3, 16'hFFFF, rb);
        model_op(1'b0, 16'h3C5A, exp);
        chk("busy_rej_capture", 32'(rb), 32'(exp));
        run_op(1'b1, 16'h0000, 1, 16'h0000, rb);
        model_op(1'b1, 16'h0000, exp);
        chk("busy_rej_loaded", 32'(rb), 32'h3C5A);

        // Reset during the 8th SHIFT cycle (cycle 9 after E0).
        begin
            int dones = 0;
            @(negedge clk);
            start = 1'b1; mode = 1'b0; pattern = 16'hBEEF;
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) dones++;
            end
            chk("mid_pre_scan", 32'(scan), 32'd1);
            reset = 1'b1;
            #1;
            chk("mid_scan", 32'(scan), 32'd0);
            chk("mid_swe", 32'(scan_write_enb), 32'd0);
            chk("mid_hold", 32'(hold_run), 32'd0);
            chk("mid_busy", 32'(busy), 32'd0);
            chk("mid_readback", 32'(readback), 32'd0);
            @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done) dones++;
            end
            chk("mid_no_done", 32'(dones), 32'd0);
        end
        run_op(1'b0, 16'h1234, 1, 16'h1234, rb);
        ref_arr = 16'h1234;
        run_op(1'b1, 16'h0000, 1, 16'h0000, rb);
        chk("mid_reload", 32'(rb), 32'h1234);

        for (int i = 0; i < 10; i++) begin
            m = 1'($urandom_range(0, 1));
            p = N'($urandom);
            run_op(m, p, 1, N'($urandom), rb);
            model_op(m, p, exp);
            chk($sformatf("rand%0d_readback", i), 32'(rb), 32'(exp));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
